insn_encoder: RTL and testbench

//  Inverse of the instruction-type decoder: packs instruction fields into 32-bit words
//  (R/I/J1/J2 formats, 5-bit opcode in [31:27]) and streams them into instruction memory.

---
 rtl/insn_encoder_if.sv | 37 +++
 rtl/insn_encoder.sv | 144 ++++++++++++++
 tb/tb_insn_encoder.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/insn_encoder_if.sv
// Bus between the program loader and the instruction encoder.
//   Field bundle (loader -> encoder): in_valid, in_kind, in_opcode, in_rd, in_rs, in_rt,
//                                     in_shamt, in_aluop, in_imm, in_target, in_last
//   Handshake back (encoder -> loader): in_ready
//   Instruction-memory write port (encoder -> memory): imem_we, imem_addr, imem_data
// master = loader/testbench side, slave = encoder side.
interface insn_encoder_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [4:0]        in_aluop;
  logic [16:0]       in_imm;
  logic [26:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output in_valid, in_kind, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop,
           in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_kind, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop,
           in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/insn_encoder.sv
// Instruction encoder: packs R/I/J1/J2 field bundles into 32-bit words (opcode in [31:27])
// and streams them into instruction memory, one word per cycle, 1-cycle latency.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   start          : 1-cycle pulse, begins a new load at address 0 (from any state)
//   bus            : field bundle handshake + imem write port (insn_encoder_if.slave)
//   done           : load finished (last word written, or memory full)
//   full           : a word has been written at the last address
//   err            : sticky opcode/kind mismatch, cleared by start
//   word_cnt       : words written since start
module insn_encoder #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  insn_encoder_if.slave     bus,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q;  // address the next accepted word goes to
  logic [ADDR_W-1:0] addr_q;       // address of the word on the write port
  logic [ADDR_W:0]   cnt_q;
  logic [31:0]       data_q;
  logic              we_q;
  logic              full_q;
  // Final word accepted (in_last or last address); ready stays low until DONE.
  logic              fin_q;

  logic              ready;
  logic              hs;
  logic              legal;
  logic [31:0]       enc;

  // Encoding and legality; fields unused by a format are ignored.
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    unique case (bus.in_kind)
      2'd0: begin
        enc   = {5'b0, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, bus.in_aluop, 2'b0};
        legal = (bus.in_opcode == 5'b00000);
      end
      2'd1: begin
        enc   = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_imm};
        legal = bus.in_opcode inside {5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000};
      end
      2'd2: begin
        enc   = {bus.in_opcode, bus.in_target};
        legal = bus.in_opcode inside {5'b00001, 5'b00011, 5'b10101, 5'b10110};
      end
      default: begin
        enc   = {bus.in_opcode, bus.in_rd, 22'b0};
        legal = (bus.in_opcode == 5'b00100);
      end
    endcase
  end

  assign hs = bus.in_valid && ready;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. start overrides everything, including a same-edge handshake.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (hs && !legal) begin
            state_d = StError;
          end else if (fin_q) begin
            state_d = StDone;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    ready         = (state_q == StLoad) && !fin_q;
    done          = (state_q == StDone);
    err           = (state_q == StError);
    full          = full_q;
    word_cnt      = cnt_q;
    bus.in_ready  = ready;
    bus.imem_we   = we_q;
    bus.imem_addr = addr_q;
    bus.imem_data = data_q;
  end

  // Write datapath: register the encoded word for one cycle; illegal bundles leave it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      full_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else if (start) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      full_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else if (hs && legal) begin
      we_q   <= 1'b1;
      addr_q <= next_addr_q;
      data_q <= enc;
      cnt_q  <= cnt_q + 1'b1;
      full_q <= (next_addr_q == LastAddr);
      fin_q  <= bus.in_last || (next_addr_q == LastAddr);
      // Address saturates at the top; nothing is accepted after the last slot.
      if (next_addr_q != LastAddr) begin
        next_addr_q <= next_addr_q + 1'b1;
      end
    end else begin
      we_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
module tb_insn_encoder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;

  always #5 clock = ~clock;

  insn_encoder_if #(.ADDR_W(12)) bus ();
  insn_encoder_if #(.ADDR_W(2))  bus_s ();

  logic        done, full, err;
  logic [12:0] word_cnt;
  logic        done_s, full_s, err_s;
  logic [2:0]  word_cnt_s;

  insn_encoder #(.ADDR_W(12)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .done     (done),
    .full     (full),
    .err      (err),
    .word_cnt (word_cnt)
  );

  insn_encoder #(.ADDR_W(2)) dut_s (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start_s),
    .bus      (bus_s),
    .done     (done_s),
    .full     (full_s),
    .err      (err_s),
    .word_cnt (word_cnt_s)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  op, rd, rs, rt, shamt, aluop;
    logic [16:0] imm;
    logic [26:0] target;
    logic        last;
  } bundle_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t sb_s[$];
  exp_t mon_e;
  exp_t mon_es;
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference encoder built from shifted fields.
  function automatic logic [31:0] model(input bundle_t b);
    case (b.kind)
      2'd0:    model = (32'(b.rd) << 22) | (32'(b.rs) << 17) | (32'(b.rt) << 12) |
                       (32'(b.shamt) << 7) | (32'(b.aluop) << 2);
      2'd1:    model = (32'(b.op) << 27) | (32'(b.rd) << 22) | (32'(b.rs) << 17) |
                       32'(b.imm);
      2'd2:    model = (32'(b.op) << 27) | 32'(b.target);
      default: model = (32'(b.op) << 27) | (32'(b.rd) << 22);
    endcase
  endfunction

  // All fields random; tests overwrite the ones the format uses.
  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.kind   = 2'($urandom);
    b.op     = 5'($urandom);
    b.rd     = 5'($urandom);
    b.rs     = 5'($urandom);
    b.rt     = 5'($urandom);
    b.shamt  = 5'($urandom);
    b.aluop  = 5'($urandom);
    b.imm    = 17'($urandom);
    b.target = 27'($urandom);
    b.last   = 1'b0;
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    bus.in_valid  = 1'b1;
    bus.in_kind   = b.kind;
    bus.in_opcode = b.op;
    bus.in_rd     = b.rd;
    bus.in_rs     = b.rs;
    bus.in_rt     = b.rt;
    bus.in_shamt  = b.shamt;
    bus.in_aluop  = b.aluop;
    bus.in_imm    = b.imm;
    bus.in_target = b.target;
    bus.in_last   = b.last;
  endtask

  task automatic drive_s(input bundle_t b);
    bus_s.in_valid  = 1'b1;
    bus_s.in_kind   = b.kind;
    bus_s.in_opcode = b.op;
    bus_s.in_rd     = b.rd;
    bus_s.in_rs     = b.rs;
    bus_s.in_rt     = b.rt;
    bus_s.in_shamt  = b.shamt;
    bus_s.in_aluop  = b.aluop;
    bus_s.in_imm    = b.imm;
    bus_s.in_target = b.target;
    bus_s.in_last   = b.last;
  endtask

  // Present a bundle for one edge; record the expected write if it should be written.
  task automatic send(input bundle_t b, input logic exp_ready, input logic [11:0] exp_addr,
                      input logic [31:0] exp_data, input bit exp_write);
    @(negedge clock);
    drive(b);
    n_tests++;
    if (bus.in_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b expected %b", bus.in_ready, exp_ready);
    end
    if (exp_write) sb.push_back('{addr: exp_addr, data: exp_data});
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid   = 1'b0;
    bus_s.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_empty(input string name);
    n_tests++;
    if (sb.size() != 0 || sb_s.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d/%0d writes outstanding, expected 0", name, sb.size(),
               sb_s.size());
    end
  endtask

  // Scoreboard monitors: every write must match the oldest expected write.
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", bus.imem_addr,
                 bus.imem_data);
      end else begin
        mon_e = sb.pop_front();
        if (bus.imem_addr !== mon_e.addr || bus.imem_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL write: addr=%0d data=%h expected addr=%0d data=%h", bus.imem_addr,
                   bus.imem_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (bus_s.imem_we === 1'b1) begin
      n_tests++;
      if (sb_s.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write_s: addr=%0d data=%h, no write expected",
                 bus_s.imem_addr, bus_s.imem_data);
      end else begin
        mon_es = sb_s.pop_front();
        if (bus_s.imem_addr !== mon_es.addr[1:0] || bus_s.imem_data !== mon_es.data) begin
          n_fail++;
          $display("FAIL write_s: addr=%0d data=%h expected addr=%0d data=%h",
                   bus_s.imem_addr, bus_s.imem_data, mon_es.addr[1:0], mon_es.data);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_tests++;
    if ({bus.imem_we, bus.in_ready, done, full, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: we/ready/done/full/err=%b expected 00000",
               {bus.imem_we, bus.in_ready, done, full, err});
    end
    n_tests++;
    if (bus.imem_addr !== 12'd0 || bus.imem_data !== 32'd0 || word_cnt !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%0d data=%h cnt=%0d expected all 0", bus.imem_addr,
               bus.imem_data, word_cnt);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus_s.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: in_ready=%b/%b expected 0/0", bus.in_ready, bus_s.in_ready);
    end
  endtask

  task automatic test_single();
    bundle_t b;
    pulse_start();
    b = rnd_bundle();
    b.kind = 2'd1; b.op = 5'b00101; b.rd = 5'd1; b.rs = 5'd0; b.imm = 17'd5;
    send(b, 1'b1, 12'd0, 32'h28400005, 1'b1);
    idle();
    n_tests++;
    if (bus.imem_we !== 1'b1 || word_cnt !== 13'd1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_write_cycle: we=%b cnt=%0d ready=%b expected 1/1/1", bus.imem_we,
               word_cnt, bus.in_ready);
    end
    @(negedge clock);
    n_tests++;
    if (bus.imem_we !== 1'b0 || word_cnt !== 13'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_after: we=%b cnt=%0d done=%b expected 0/1/0", bus.imem_we, word_cnt,
               done);
    end
    check_empty("t1");
  endtask

  task automatic test_back_to_back();
    bundle_t b;
    pulse_start();
    n_tests++;
    if (word_cnt !== 13'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_restart: cnt=%0d ready=%b expected 0/1", word_cnt, bus.in_ready);
    end
    b = rnd_bundle();
    b.kind = 2'd0; b.op = 5'd0; b.rd = 5'd3; b.rs = 5'd1; b.rt = 5'd2; b.shamt = 5'd0;
    b.aluop = 5'd0;
    send(b, 1'b1, 12'd0, 32'h00C22000, 1'b1);
    b = rnd_bundle();
    b.kind = 2'd2; b.op = 5'b00011; b.target = 27'h100;
    send(b, 1'b1, 12'd1, 32'h18000100, 1'b1);
    b = rnd_bundle();
    b.kind = 2'd3; b.op = 5'b00100; b.rd = 5'd31; b.last = 1'b1;
    send(b, 1'b1, 12'd2, 32'h27C00000, 1'b1);
    idle();
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_last_write: ready=%b we=%b done=%b expected 0/1/0", bus.in_ready,
               bus.imem_we, done);
    end
    @(negedge clock);
    n_tests++;
    if (done !== 1'b1 || word_cnt !== 13'd3 || bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0)
    begin
      n_fail++;
      $display("FAIL t2_done: done=%b cnt=%0d ready=%b we=%b expected 1/3/0/0", done, word_cnt,
               bus.in_ready, bus.imem_we);
    end
    // DONE ignores further bundles.
    b = rnd_bundle();
    b.kind = 2'd2; b.op = 5'b10101;
    send(b, 1'b0, 12'd0, 32'd0, 1'b0);
    idle();
    n_tests++;
    if (done !== 1'b1 || word_cnt !== 13'd3 || bus.imem_addr !== 12'd2) begin
      n_fail++;
      $display("FAIL t2_hold: done=%b cnt=%0d addr=%0d expected 1/3/2", done, word_cnt,
               bus.imem_addr);
    end
    check_empty("t2");
  endtask

  task automatic test_error();
    bundle_t b;
    pulse_start();
    b = rnd_bundle();
    b.kind = 2'd1; b.op = 5'b01000;
    send(b, 1'b1, 12'd0, model(b), 1'b1);
    b = rnd_bundle();
    b.kind = 2'd1; b.op = 5'b00001;
    send(b, 1'b1, 12'd0, 32'd0, 1'b0);
    idle();
    n_tests++;
    if (err !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_err: err=%b ready=%b we=%b done=%b expected 1/0/0/0", err,
               bus.in_ready, bus.imem_we, done);
    end
    n_tests++;
    if (word_cnt !== 13'd1 || bus.imem_addr !== 12'd0) begin
      n_fail++;
      $display("FAIL t3_unchanged: cnt=%0d addr=%0d expected 1/0", word_cnt, bus.imem_addr);
    end
    pulse_start();
    n_tests++;
    if (err !== 1'b0 || bus.imem_addr !== 12'd0 || word_cnt !== 13'd0 || bus.in_ready !== 1'b1)
    begin
      n_fail++;
      $display("FAIL t3_clear: err=%b addr=%0d cnt=%0d ready=%b expected 0/0/0/1", err,
               bus.imem_addr, word_cnt, bus.in_ready);
    end
    // R with a nonzero opcode is illegal too.
    b = rnd_bundle();
    b.kind = 2'd0; b.op = 5'b00010;
    send(b, 1'b1, 12'd0, 32'd0, 1'b0);
    idle();
    n_tests++;
    if (err !== 1'b1 || word_cnt !== 13'd0) begin
      n_fail++;
      $display("FAIL t3_r_op: err=%b cnt=%0d expected 1/0", err, word_cnt);
    end
    check_empty("t3");
  endtask

  task automatic test_full();
    bundle_t b;
    @(negedge clock);
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      b = rnd_bundle();
      b.kind = 2'd2; b.op = 5'b10110; b.target = 27'(i * 7 + 1);
      drive_s(b);
      n_tests++;
      if (bus_s.in_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL t4_ready_%0d: in_ready=%b expected %b", i, bus_s.in_ready, (i < 4));
      end
      if (i < 4) sb_s.push_back('{addr: 12'(i), data: model(b)});
      if (i == 4) begin
        n_tests++;
        if (full_s !== 1'b1 || done_s !== 1'b0) begin
          n_fail++;
          $display("FAIL t4_full_early: full=%b done=%b expected 1/0", full_s, done_s);
        end
      end
    end
    idle();
    n_tests++;
    if (done_s !== 1'b1 || full_s !== 1'b1 || word_cnt_s !== 3'd4 || bus_s.imem_we !== 1'b0 ||
        bus_s.imem_addr !== 2'd3) begin
      n_fail++;
      $display("FAIL t4_done: done=%b full=%b cnt=%0d we=%b addr=%0d expected 1/1/4/0/3",
               done_s, full_s, word_cnt_s, bus_s.imem_we, bus_s.imem_addr);
    end
    check_empty("t4");
  endtask

  task automatic test_reset_midload();
    bundle_t b;
    pulse_start();
    b = rnd_bundle();
    b.kind = 2'd1; b.op = 5'b00110;
    send(b, 1'b1, 12'd0, model(b), 1'b0);
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.imem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_pre: we=%b expected 1", bus.imem_we);
    end
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if ({bus.imem_we, bus.in_ready, done, full, err} !== 5'b0 || bus.imem_addr !== 12'd0 ||
        bus.imem_data !== 32'd0 || word_cnt !== 13'd0) begin
      n_fail++;
      $display("FAIL t5_reset: we/ready/done/full/err=%b addr=%0d data=%h cnt=%0d expected 0",
               {bus.imem_we, bus.in_ready, done, full, err}, bus.imem_addr, bus.imem_data,
               word_cnt);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_idle: ready=%b we=%b expected 0/0", bus.in_ready, bus.imem_we);
    end
    check_empty("t5");
  endtask

  task automatic test_start_collision();
    bundle_t b;
    pulse_start();
    @(negedge clock);
    b = rnd_bundle();
    b.kind = 2'd2; b.op = 5'b00001;
    drive(b);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    b = rnd_bundle();
    b.kind = 2'd3; b.op = 5'b00100;
    drive(b);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.imem_we !== 1'b0 || word_cnt !== 13'd0) begin
      n_fail++;
      $display("FAIL t6_dropped: ready=%b we=%b cnt=%0d expected 1/0/0", bus.in_ready,
               bus.imem_we, word_cnt);
    end
    sb.push_back('{addr: 12'd0, data: model(b)});
    idle();
    n_tests++;
    if (word_cnt !== 13'd1 || bus.imem_addr !== 12'd0) begin
      n_fail++;
      $display("FAIL t6_next: cnt=%0d addr=%0d expected 1/0", word_cnt, bus.imem_addr);
    end
    @(negedge clock);
    check_empty("t6");
  endtask

  initial begin
    drive(rnd_bundle());
    drive_s(rnd_bundle());
    bus.in_valid   = 1'b0;
    bus_s.in_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_full();
    test_reset_midload();
    test_start_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
